// File: rtl/program_loader_pkg.sv
// Shared types for the boot-time program loader: FSM state encoding,
// error codes and small state-classification helpers.
package program_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        CSUM  = 3'd5,
        DONE  = 3'd6,
        ERROR = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_COUNT   = 2'd1,
        ERR_CSUM    = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_t;

    // States in which a stream byte may be consumed.
    function automatic logic accepts_bytes(input state_t s);
        return s inside {HDR0, HDR1, DATA, CSUM};
    endfunction

    // States that belong to a frame in progress.
    function automatic logic in_frame(input state_t s);
        return !(s inside {IDLE, DONE, ERROR});
    endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Four-byte big-endian shift register with byte counter and a running XOR
// of every byte presented on accum.
module word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        shift,
    input  logic        accum,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic [7:0]  xor_sum,
    output logic        full
);

    logic [1:0] byte_cnt;

    // High on the shift that completes a word; the counter wraps back to 0.
    assign full = shift && (byte_cnt == 2'd3);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word     <= '0;
            byte_cnt <= '0;
            xor_sum  <= '0;
        end else if (clear) begin
            word     <= '0;
            byte_cnt <= '0;
            xor_sum  <= '0;
        end else begin
            if (shift) begin
                word     <= {word[23:0], data};
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (accum) begin
                xor_sum <= xor_sum ^ data;
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader: receives a framed byte stream, writes big-endian
// words to consecutive RAM addresses and releases the CPU once the checksum holds.
module program_loader
    import program_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MAX_WORDS      = 512,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        byteValid,
    input  logic [7:0]  byteData,
    output logic        byteReady,
    output logic        memWrite,
    output logic [31:0] memAddress,
    output logic [31:0] memWriteData,
    output logic        cpuRst,
    output logic        busy,
    output logic        done,
    output logic [1:0]  errorCode,
    output logic [15:0] wordCount
);

    localparam int                IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [15:0]       MAX_COUNT  = 16'(MAX_WORDS);

    state_t            state;
    state_t            next_state;
    err_t              err_q;
    err_t              err_next;
    logic [15:0]       frame_count;
    logic [IDLE_W-1:0] idle_cnt;

    logic        accept;
    logic        load_start;
    logic        timed_out;
    logic [15:0] count_rx;
    logic [15:0] count_inc;
    logic [7:0]  xor_sum;
    logic        word_full;

    assign accept     = byteValid && byteReady;
    assign load_start = start && !in_frame(state);
    assign timed_out  = (idle_cnt == IDLE_LIMIT);
    assign count_rx   = {frame_count[15:8], byteData};
    assign count_inc  = wordCount + 16'd1;
    assign errorCode  = err_q;

    word_assembler u_word (
        .clk     (clk),
        .rst     (rst),
        .clear   (load_start),
        .shift   (accept && (state == DATA)),
        .accum   (accept),
        .data    (byteData),
        .word    (memWriteData),
        .xor_sum (xor_sum),
        .full    (word_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // NOTE: every always_comb output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        next_state = state;
        err_next   = err_q;
        unique case (state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    next_state = HDR0;
                    err_next   = ERR_NONE;
                end
            end
            HDR0: begin
                if (accept) next_state = HDR1;
                else if (timed_out) begin
                    next_state = ERROR;
                    err_next   = ERR_TIMEOUT;
                end
            end
            HDR1: begin
                if (accept) begin
                    if (count_rx == 16'd0 || count_rx > MAX_COUNT) begin
                        next_state = ERROR;
                        err_next   = ERR_COUNT;
                    end else begin
                        next_state = DATA;
                    end
                end else if (timed_out) begin
                    next_state = ERROR;
                    err_next   = ERR_TIMEOUT;
                end
            end
            DATA: begin
                if (word_full) next_state = WRITE;
                else if (!accept && timed_out) begin
                    next_state = ERROR;
                    err_next   = ERR_TIMEOUT;
                end
            end
            WRITE: begin
                next_state = (count_inc == frame_count) ? CSUM : DATA;
            end
            CSUM: begin
                if (accept) begin
                    if (byteData == xor_sum) next_state = DONE;
                    else begin
                        next_state = ERROR;
                        err_next   = ERR_CSUM;
                    end
                end else if (timed_out) begin
                    next_state = ERROR;
                    err_next   = ERR_TIMEOUT;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Status outputs are decoded from next_state so they change on the same
    // edge as the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byteReady <= 1'b0;
            memWrite  <= 1'b0;
            cpuRst    <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_q     <= ERR_NONE;
        end else begin
            byteReady <= accepts_bytes(next_state);
            memWrite  <= (next_state == WRITE);
            cpuRst    <= (next_state != DONE);
            busy      <= in_frame(next_state);
            done      <= (next_state == DONE);
            err_q     <= err_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wordCount   <= '0;
            memAddress  <= BASE_ADDR;
            frame_count <= '0;
        end else begin
            if (load_start) begin
                wordCount  <= '0;
                memAddress <= BASE_ADDR;
            end else if (state == WRITE) begin
                wordCount  <= count_inc;
                memAddress <= memAddress + 32'd4;
            end
            if (accept && state == HDR0) frame_count[15:8] <= byteData;
            if (accept && state == HDR1) frame_count[7:0]  <= byteData;
        end
    end

    // Idle counter saturates at the limit; it only runs while a frame is open.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt <= '0;
        end else if (load_start || accept) begin
            idle_cnt <= '0;
        end else if (busy && !timed_out) begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader with a short timeout.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        byteValid = 1'b0;
    logic [7:0]  byteData = 8'h00;
    logic        byteReady;
    logic        memWrite;
    logic [31:0] memAddress;
    logic [31:0] memWriteData;
    logic        cpuRst;
    logic        busy;
    logic        done;
    logic [1:0]  errorCode;
    logic [15:0] wordCount;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:15];
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    logic [7:0]  frame [$];

    program_loader #(
        .BASE_ADDR      (32'h0000_0000),
        .MAX_WORDS      (512),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .byteValid    (byteValid),
        .byteData     (byteData),
        .byteReady    (byteReady),
        .memWrite     (memWrite),
        .memAddress   (memAddress),
        .memWriteData (memWriteData),
        .cpuRst       (cpuRst),
        .busy         (busy),
        .done         (done),
        .errorCode    (errorCode),
        .wordCount    (wordCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // RAM model and write log; byteReady must be low in every write cycle.
    always @(negedge clk) begin
        if (memWrite === 1'b1) begin
            mem[memAddress[5:2]] = memWriteData;
            wr_addr.push_back(memAddress);
            wr_data.push_back(memWriteData);
            check("ready_low_in_write", {31'd0, byteReady}, 32'd0);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one byte and return on the negedge after it was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        byteValid = 1'b1;
        byteData  = b;
        n = 0;
        while (byteReady !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait_bound", {31'd0, (n < 50)}, 32'd1);
        @(negedge clk);
    endtask

    task automatic send_frame();
        foreach (frame[i]) send_byte(frame[i]);
        byteValid = 1'b0;
    endtask

    initial begin
        // Reset values
        @(negedge clk);
        check("rst_cpuRst", {31'd0, cpuRst}, 32'd1);
        check("rst_byteReady", {31'd0, byteReady}, 32'd0);
        check("rst_memWrite", {31'd0, memWrite}, 32'd0);
        check("rst_memAddress", memAddress, 32'h0);
        check("rst_memWriteData", memWriteData, 32'h0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_errorCode", {30'd0, errorCode}, 32'd0);
        check("rst_wordCount", {16'd0, wordCount}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Good two-word frame, byteValid held high throughout
        pulse_start();
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_ready", {31'd0, byteReady}, 32'd1);
        frame = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                  8'h01, 8'h23, 8'h45, 8'h67, 8'h20};
        send_frame();
        check("good_done", {31'd0, done}, 32'd1);
        check("good_cpuRst", {31'd0, cpuRst}, 32'd0);
        check("good_busy", {31'd0, busy}, 32'd0);
        check("good_err", {30'd0, errorCode}, 32'd0);
        check("good_wordCount", {16'd0, wordCount}, 32'd2);
        check("good_memAddress", memAddress, 32'h8);
        check("good_nwrites", wr_addr.size(), 32'd2);
        if (wr_addr.size() == 2) begin
            check("good_addr0", wr_addr[0], 32'h0);
            check("good_data0", wr_data[0], 32'hDEADBEEF);
            check("good_addr1", wr_addr[1], 32'h4);
            check("good_data1", wr_data[1], 32'h01234567);
        end

        // Same frame with bad checksum
        wr_addr.delete();
        wr_data.delete();
        mem[0] = 32'h0;
        mem[1] = 32'h0;
        pulse_start();
        check("restart_cpuRst", {31'd0, cpuRst}, 32'd1);
        check("restart_done", {31'd0, done}, 32'd0);
        check("restart_wordCount", {16'd0, wordCount}, 32'd0);
        frame[10] = 8'h21;
        send_frame();
        check("csum_err", {30'd0, errorCode}, 32'd2);
        check("csum_cpuRst", {31'd0, cpuRst}, 32'd1);
        check("csum_done", {31'd0, done}, 32'd0);
        check("csum_mem0", mem[0], 32'hDEADBEEF);
        check("csum_mem1", mem[1], 32'h01234567);

        // Zero count
        wr_addr.delete();
        pulse_start();
        check("restart_err_cleared", {30'd0, errorCode}, 32'd0);
        frame = '{8'h00, 8'h00};
        send_frame();
        check("zero_err", {30'd0, errorCode}, 32'd1);
        check("zero_busy", {31'd0, busy}, 32'd0);
        check("zero_nwrites", wr_addr.size(), 32'd0);

        // 513 words: over the limit
        pulse_start();
        frame = '{8'h02, 8'h01};
        send_frame();
        check("over_err", {30'd0, errorCode}, 32'd1);

        // 512 words: accepted, then left to time out
        pulse_start();
        frame = '{8'h02, 8'h00};
        send_frame();
        check("max_err", {30'd0, errorCode}, 32'd0);
        check("max_busy", {31'd0, busy}, 32'd1);
        check("max_ready", {31'd0, byteReady}, 32'd1);
        repeat (17) @(negedge clk);
        check("max_timeout", {30'd0, errorCode}, 32'd3);

        // Timeout exactly 17 cycles after the last accepted byte
        pulse_start();
        frame = '{8'h00, 8'h01, 8'hDE};
        send_frame();
        repeat (16) @(negedge clk);
        check("to_not_yet", {30'd0, errorCode}, 32'd0);
        check("to_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("to_err", {30'd0, errorCode}, 32'd3);
        check("to_cpuRst", {31'd0, cpuRst}, 32'd1);
        check("to_busy_low", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-DATA
        pulse_start();
        frame = '{8'h00, 8'h01, 8'hDE, 8'hAD};
        send_frame();
        #2 rst = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ready", {31'd0, byteReady}, 32'd0);
        check("abort_cpuRst", {31'd0, cpuRst}, 32'd1);
        check("abort_memAddress", memAddress, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // start during DATA is ignored
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        frame = '{8'h00, 8'h01, 8'hAA, 8'hBB};
        send_frame();
        pulse_start();
        check("ign_busy", {31'd0, busy}, 32'd1);
        frame = '{8'hCC, 8'hDD, 8'h01};
        send_frame();
        check("ign_done", {31'd0, done}, 32'd1);
        check("ign_wordCount", {16'd0, wordCount}, 32'd1);
        check("ign_nwrites", wr_addr.size(), 32'd1);
        if (wr_data.size() == 1) check("ign_data", wr_data[0], 32'hAABBCCDD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
